// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle RV32I instruction sequencer.
// Owns the PC and instruction register and commits next_pc once per instruction.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        cs_mem_access,
    input  logic        cs_reg_write,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic [31:0] next_pc,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        reg_write_en,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic        halted,
    output logic [31:0] retired_count
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] retired_q, retired_d;
    logic        misaligned;

    assign misaligned = next_pc[1:0] != 2'b00;

    // Acks only matter in the state that raised the matching request,
    // so stray acks elsewhere fall through the case untouched.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        trap_pc_d = trap_pc_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = cs_mem_access ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (misaligned) begin
                    trap_pc_d = pc_q;
                    pc_d      = TRAP_VECTOR;
                end else begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                end
                state_d = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VECTOR;
            instr_q   <= NOP;
            trap_pc_q <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            trap_pc_q <= trap_pc_d;
            retired_q <= retired_d;
        end
    end

    // Requests and strobes are masked while reset is held so an in-flight
    // handshake is dropped in the same cycle reset appears.
    assign imem_req      = (state_q == S_FETCH) && !reset;
    assign dmem_req      = (state_q == S_MEM) && !reset;
    assign reg_write_en  = (state_q == S_WB) && !reset && !misaligned && cs_reg_write;
    assign trap          = (state_q == S_WB) && !reset && misaligned;
    assign halted        = (state_q == S_HALT);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign trap_pc       = trap_pc_q;
    assign retired_count = retired_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the RV32I core. Owns the architectural PC and instruction register, steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WB states, and commits the branch control unit's `next_pc` once per instruction. Handles instruction/data memory req/ack handshakes, misaligned-target traps, halt requests and a retired-instruction counter.

## Interface

- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0010: PC loaded on a misaligned branch/jump target.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register.
- `cs_mem_access`  in  1  decoded: current instruction is a load/store.
- `cs_reg_write`  in  1  decoded: current instruction writes rd.
- `dmem_req`  out  1  data memory request.
- `dmem_ack`  in  1  data access complete.
- `next_pc`  in  32  target from branch control unit (valid in EXECUTE and WB).
- `halt_req`  in  1  stop after the current instruction retires.
- `pc`  out  32  current PC.
- `reg_write_en`  out  1  register file write strobe.
- `trap`  out  1  one-cycle pulse: misaligned target taken.
- `trap_pc`  out  32  PC of the last trapping instruction.
- `halted`  out  1  high while in HALT.
- `retired_count`  out  32  instructions retired.

## Operation

- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: `imem_req`=1. On `imem_ack`: `instr` <= `imem_rdata`, go DECODE. Else stay.
- DECODE: one cycle, no outputs asserted; go EXECUTE.
- EXECUTE: one cycle; `cs_mem_access`=1 -> MEM, else -> WB.
- MEM: `dmem_req`=1 until `dmem_ack`, then WB.
- WB (one cycle): misaligned = `next_pc[1:0]` != 2'b00.
  - Not misaligned: `reg_write_en` = `cs_reg_write`; `pc` <= `next_pc`; `retired_count` += 1 (mod 2^32, wraps to 0).
  - Misaligned: `reg_write_en`=0; `trap`=1; `trap_pc` <= `pc`; `pc` <= `TRAP_VECTOR`; counter unchanged.
  - Then `halt_req`=1 -> HALT, else FETCH.
- HALT: `halted`=1, no requests; `halt_req`=0 -> FETCH.
- `halt_req` sampled only in WB and HALT; asserting it mid-instruction never aborts a handshake.
- Acks sampled only while the matching req is high; stray acks ignored.
- `imem_req`, `dmem_req`, `reg_write_en`, `trap`, `halted` decoded combinationally from state (plus WB qualifiers); never high simultaneously except as listed.

## Timing

- Reset (sync, any state incl. mid-handshake): state=FETCH, `pc`=`RESET_VECTOR`, `instr`=32'h0000_0013 (NOP), `trap_pc`=0, `retired_count`=0; during reset cycle all req/strobe outputs 0. Outstanding request abandoned; memory must tolerate dropped req.
- First `imem_req` in the cycle after `reset` deasserts.
- Same-cycle ack allowed: zero-wait non-memory instruction = 4 cycles (FETCH, DECODE, EXECUTE, WB); zero-wait load/store = 5.
- Each fetch wait cycle adds 1; each data wait cycle adds 1.
- `pc` changes only on the WB->next edge (or reset); stable through the whole instruction so the branch unit's `pc + imm` is consistent.
- `reg_write_en` and `trap` high exactly one cycle per instruction at most.
- HALT->FETCH: `imem_req` in the cycle after `halt_req` observed low.

## Test plan

- Reset release, zero-wait imem returning ADDI, `next_pc`=pc+4 -> `imem_addr` 0,4,8 every 4 cycles; `reg_write_en` pulse in each WB; `retired_count` 3 after three instructions.
- `imem_ack` delayed 3 cycles, then a load with `dmem_ack` delayed 2 -> instruction takes 10 cycles; `dmem_req` held high 3 cycles; `pc` unchanged until WB edge.
- WB with `next_pc`=32'h0000_0102, `cs_reg_write`=1 at pc=32'h40 -> `trap` pulse, `reg_write_en`=0, `trap_pc`=32'h40, next `imem_addr`=32'h10, counter unchanged.
- `halt_req` raised during FETCH wait -> fetch completes, instruction retires, `halted`=1 with no reqs; drop `halt_req` -> fetch at `next_pc` next cycle.
- `reset` asserted mid-MEM with `dmem_req` high -> next cycle `dmem_req`=0, `pc`=RESET_VECTOR, `instr`=32'h13, counter 0; stray `dmem_ack` afterwards ignored.
- Preload counter path to 32'hFFFF_FFFF (force), retire one -> `retired_count`=0.
